// File: rtl/alu_pkg.sv
// Shared ALU definitions: control encodings, flag bit positions, the
// multiply sequencer state type and its step count, plus the helper that
// derives the {N,Z,C,V} flags of a 64-bit product.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int MUL_STEPS = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

  // Product flags: V reports a result that does not fit in 32 bits.
  function automatic logic [3:0] mul_flags_f(input logic [63:0] p);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = p[63];
    f[FLAG_Z] = (p == 64'd0);
    f[FLAG_C] = 1'b0;
    f[FLAG_V] = |p[63:32];
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq_if.sv
// Start/busy/done handshake and operand/result bus of the multiply sequencer.
//   start        : request, accepted only while the sequencer is idle
//   multiplicand : operand A, sampled on the accept edge
//   multiplier   : operand B, sampled on the accept edge
//   busy         : high while an operation runs and during the done cycle
//   done         : one-cycle pulse, product and mul_flags valid
//   product      : 64-bit registered result, held until the next result
//   mul_flags    : {N,Z,C,V} of product
// master = requester (execute stage), slave = the sequencer.
interface alu_mul_seq_if;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [3:0]  mul_flags;

  modport master (output start, multiplicand, multiplier,
                  input  busy, done, product, mul_flags);
  modport slave  (input  start, multiplicand, multiplier,
                  output busy, done, product, mul_flags);
endinterface

// File: rtl/alu.sv
// 32-bit ALU: ADD, SUB, AND, ORR with {N,Z,C,V} flags.
//   i_a, i_b        : operands
//   i_alu_control   : operation select (alu_pkg encodings)
//   o_result        : 32-bit result
//   o_flags         : {N,Z,C,V}; C is carry-out (no-borrow for SUB),
//                     C and V are zero for logic operations
module alu
  import alu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [1:0]  i_alu_control,
  output logic [31:0] o_result,
  output logic [3:0]  o_flags
);

  logic [32:0] w_sum;
  logic [31:0] w_b_eff;
  logic        w_arith;

  // SUB is a + ~b + 1; w_b_eff is the operand actually added, for V.
  assign w_arith = ~i_alu_control[1];
  assign w_b_eff = i_alu_control[0] ? ~i_b : i_b;

  always_comb begin
    w_sum = '0;
    unique case (i_alu_control)
      ALU_ADD: w_sum = {1'b0, i_a} + {1'b0, i_b};
      ALU_SUB: w_sum = {1'b0, i_a} + {1'b0, ~i_b} + 33'd1;
      ALU_AND: w_sum = {1'b0, i_a & i_b};
      ALU_ORR: w_sum = {1'b0, i_a | i_b};
      default: w_sum = '0;
    endcase
  end

  assign o_result        = w_sum[31:0];
  assign o_flags[FLAG_N] = w_sum[31];
  assign o_flags[FLAG_Z] = (w_sum[31:0] == 32'd0);
  assign o_flags[FLAG_C] = w_arith & w_sum[32];
  assign o_flags[FLAG_V] = w_arith & (i_a[31] == w_b_eff[31]) & (w_sum[31] != i_a[31]);

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned 32x32->64 shift-add multiplier built around one ALU
// (ADD only, carry flag consumed), one iteration per clock.
//   clk      : system clock
//   reset_n  : synchronous active-low reset; discards any operation in flight
//   bus      : alu_mul_seq_if slave (start/operands in, busy/done/product/flags out)
// Parameters: N_BITS must be 32 (ALU width); EARLY_EXIT=1 ends the run once
// the remaining multiplier bits are all zero.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int N_BITS     = 32,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_mul_seq_if.slave  bus
);

  if (N_BITS != 32) begin : g_width_check
    $error("alu_mul_seq: N_BITS must equal the ALU width of 32");
  end

  mul_state_t  r_state;
  logic [31:0] r_mcand;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [4:0]  r_cnt;
  logic [63:0] r_product;
  logic [3:0]  r_flags;
  logic        r_busy;
  logic        r_done;

  logic [31:0] w_alu_result;
  logic [3:0]  w_alu_flags;
  logic [31:0] w_hi_new;
  logic        w_c;
  logic [63:0] w_shift;
  logic [31:0] w_rem_mask;
  logic        w_rem_zero;
  logic        w_last;
  logic [63:0] w_final;
  logic        w_unused_alu_flags;

  alu u_alu (
    .i_a           (r_hi),
    .i_b           (r_mcand),
    .i_alu_control (ALU_ADD),
    .o_result      (w_alu_result),
    .o_flags       (w_alu_flags)
  );

  // Only the carry is meaningful for the unsigned accumulate.
  assign w_unused_alu_flags = ^{w_alu_flags[FLAG_N], w_alu_flags[FLAG_Z], w_alu_flags[FLAG_V]};

  assign w_hi_new = r_lo[0] ? w_alu_result : r_hi;
  assign w_c      = r_lo[0] & w_alu_flags[FLAG_C];
  // 65-bit {c,hi,lo} shifted right by one, low 64 bits kept.
  assign w_shift  = {w_c, w_hi_new, r_lo[31:1]};

  // After iteration r_cnt, the unconsumed multiplier bits are the low
  // (31 - r_cnt) bits of the shifted lo half.
  assign w_rem_mask = 32'hFFFF_FFFF >> ({1'b0, r_cnt} + 6'd1);
  assign w_rem_zero = ((w_shift[31:0] & w_rem_mask) == 32'd0);
  assign w_last     = (r_cnt == 5'(MUL_STEPS - 1)) || (EARLY_EXIT && w_rem_zero);

  // Early exit folds the remaining zero-add iterations into plain shifts;
  // at the terminal count the shift amount is zero.
  assign w_final = EARLY_EXIT ? (w_shift >> (6'd31 - {1'b0, r_cnt})) : w_shift;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_flags   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mcand <= bus.multiplicand;
            r_hi    <= '0;
            r_lo    <= bus.multiplier;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_last) begin
            {r_hi, r_lo} <= w_final;
            r_product    <= w_final;
            r_flags      <= mul_flags_f(w_final);
            r_done       <= 1'b1;
            r_state      <= DONE;
          end else begin
            {r_hi, r_lo} <= w_shift;
            r_cnt        <= r_cnt + 5'd1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.product   = r_product;
  assign bus.mul_flags = r_flags;

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle unsigned 32x32->64 shift-add multiplier controller.
- Sequences one instance of the team's 32-bit ALU, using its add operation and carry flag, one iteration per clock.
- Sits beside the ALU in the execute stage and serves multiply-class instructions through a start/busy/done handshake.
- Produces a 64-bit product plus a 4-bit flag bus in the same {N,Z,C,V} layout as the ALU flags.

Parameters:
- N_BITS, 32, operand width. Fixed to the ALU width; any other value is a synthesis-time error.
- EARLY_EXIT, 0. When 1, RUN ends as soon as the remaining multiplier bits are all zero.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- start  input  1  request; accepted only in IDLE.
- multiplicand  input  32  operand A; sampled when start is accepted.
- multiplier  input  32  operand B; sampled when start is accepted.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; product and flags valid.
- product  output  64  registered result; held until next accepted start.
- mul_flags  output  4  {negative, zero, carry, overflow}; registered with product.

Behaviour:
- Reset (reset_n=0 at an edge, any state, including mid-RUN):
  - state<=IDLE; busy=0, done=0, product=0, mul_flags=0.
  - Iteration counter, hi/lo/multiplicand registers all cleared.
  - In-flight operation is discarded; no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - On an edge with start=1: mcand<=multiplicand, hi<=0, lo<=multiplier, cnt<=0, state<=RUN.
  - Accept edge = edge k.
- RUN: one iteration per edge.
  - ALU drives a=hi, b=mcand, alu_control=2'b00 (ADD).
  - If lo[0]=1: {c,hi_new}={ALU carry flag, ALU result}. Else {c,hi_new}={0,hi}.
  - Update {hi,lo} <= {c,hi_new,lo} >> 1, i.e. a 65-bit right shift, keeping the low 64 bits.
  - cnt<=cnt+1.
  - Exit to DONE at the edge where cnt==31 (EARLY_EXIT=0). For the default, this is edge k+32.
  - EARLY_EXIT=1: exit at the first edge where the post-shift remaining multiplier bits are zero, with the remaining hi/lo shifts applied in that same edge. A multiplier of 0 exits after 1 iteration.
  - The counter never wraps: 5-bit counter, terminal value 31.
- Entering DONE: at the edge into DONE, product<={hi,lo} and mul_flags are registered.
  - N=product[63].
  - Z=(product==0).
  - C=0.
  - V=|product[63:32], i.e. the result does not fit in 32 bits.
- DONE:
  - done=1 and busy=1 for exactly one cycle; state<=IDLE at the next edge.
  - Default latency: done is high in the cycle after edge k+32, which is the 33rd cycle after the accept cycle.
- start handling:
  - start is ignored in RUN and DONE; no queuing.
  - Operand inputs are don't-care except at the accept edge.
  - Back-to-back: start in the cycle after done is accepted normally.
- product and mul_flags are stable from done until the edge of the next accepted start, where they are not modified. They change only on entry to DONE or on reset.
- ALU carry is consumed only when lo[0]=1; the ALU N/Z/V outputs are unused.

Decomposition:
- Shared package alu_pkg:
  - ALU control encodings: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_ORR=2'b11.
  - Flag bit indices: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - mul_state_t enum {IDLE, RUN, DONE}.
  - MUL_STEPS=32.
- One sub-module: the existing alu, instantiated once. Only its alu_control=ALU_ADD path is exercised.
- Shift register, counter and FSM stay inline.

Test Plan:
- Basic: reset_n low 2 cycles, then start with 3 x 5 -> done exactly 33 cycles after the accept cycle; product=0x0000_0000_0000_000F, mul_flags=4'b0000; busy high throughout.
- Max operands: 0xFFFF_FFFF x 0xFFFF_FFFF -> product=0xFFFF_FFFE_0000_0001, mul_flags=4'b1001 (N=1, V=1). Exercises the carry on every add.
- Zero: 0x1234_5678 x 0 -> product=0, mul_flags=4'b0100. With EARLY_EXIT=1, done arrives 2 cycles after accept; with EARLY_EXIT=0, 33 cycles.
- Busy ignore: 7 x 9 accepted, then start with 2 x 2 on cycles 5 and 33 (DONE) -> single result 63 (0x3F); no second done until a new start is issued in IDLE.
- Reset mid-op: accept 0x8000_0000 x 2, assert reset_n=0 at cycle 10 -> next cycle busy=0, product=0, mul_flags=0, no done pulse. A new start with 4 x 4 then yields 16.
- Back-to-back: start held high continuously with 0x10000 x 0x10000 -> successive dones every 34 cycles, each with product=0x0000_0001_0000_0000 and mul_flags=4'b0001.
